ysyx_22050598_line_mem_bridge: RTL

YSYX_22050598_LINE_MEM_BRIDGE -- requirements
Module: ysyx_22050598_line_mem_bridge

---
 rtl/ysyx_22050598_line_mem_bridge_pkg.sv | 32 +++
 rtl/ysyx_22050598_line_mem_bridge_dfflr.sv | 21 ++
 rtl/ysyx_22050598_line_mem_bridge.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050598_line_mem_bridge_pkg.sv
// Shared widths, FSM state encodings and beat-request record for the line/memory bridge.
// The write path is compiled in only when YSYX_22050598_LINE_WRITE_EN is defined.
package ysyx_22050598_line_mem_bridge_pkg;

   localparam int LINE_W = 128;
   localparam int BEAT_W = 64;
   localparam int ADDR_W = 64;
   localparam int STRB_W = BEAT_W / 8;
   localparam int TAG_W  = ADDR_W - 4;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD_REQ  = 3'd1;
   localparam logic [2:0] ST_RD_WAIT = 3'd2;
   localparam logic [2:0] ST_WR_REQ  = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;
   localparam logic [2:0] ST_HOLD    = 3'd5;

   typedef struct packed {
      logic              valid;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [BEAT_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } bus_req_t;

   // Beat 0 sits at offset 0 of the 16-byte line, beat 1 at offset 8.
   function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0] line,
                                                   input logic            beat);
      return {line, beat, 3'b000};
   endfunction

endpackage

// File: rtl/ysyx_22050598_line_mem_bridge_dfflr.sv
// Generic load-enabled register with asynchronous active-low clear; the bridge builds all
// of its state (FSM, beat, address, line buffers, error flag) from this cell.
module ysyx_22050598_sirv_gnrl_dfflr #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          lden,
   input  logic [DW-1:0] dnxt,
   output logic [DW-1:0] qout
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qout <= '0;
      end else if (lden) begin
         qout <= dnxt;
      end
   end

endmodule

// File: rtl/ysyx_22050598_line_mem_bridge.sv
// Splits 128-bit cache line refills/writebacks into two 64-bit bus beats.
// Define YSYX_22050598_LINE_WRITE_EN to build the writeback path; otherwise writebacks error out.
//
//   state    | meaning
//   IDLE     | waiting for a line request (write has priority)
//   RD_REQ   | presenting a read beat request, waiting for bus_ready
//   RD_WAIT  | read beat accepted, waiting for bus_rvalid
//   WR_REQ   | presenting a write beat, waiting for bus_ready
//   DONE     | one-cycle mem_req_ready pulse
//   HOLD     | one dead cycle so the requester can drop its request
module ysyx_22050598_line_mem_bridge
   import ysyx_22050598_line_mem_bridge_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req_r,
   input  logic              mem_req_w,
   input  logic [ADDR_W-1:0] mem_req_addr,
   input  logic [LINE_W-1:0] mem_w_data,
   output logic [LINE_W-1:0] mem_r_data,
   output logic              mem_req_ready,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [BEAT_W-1:0] bus_wdata,
   output logic [STRB_W-1:0] bus_wstrb,
   input  logic              bus_rvalid,
   input  logic [BEAT_W-1:0] bus_rdata,
   output logic              bridge_err
);

   logic [2:0]       state_r;
   logic [2:0]       state_nxt;
   logic             beat_r;
   logic             beat_nxt;
   logic [TAG_W-1:0] line_addr_r;
   logic             accept;
   logic             rlo_en;
   logic             rhi_en;
   logic             err_set;
   bus_req_t         bus_req;

   always_comb begin
      state_nxt = state_r;
      beat_nxt  = beat_r;
      accept    = 1'b0;
      rlo_en    = 1'b0;
      rhi_en    = 1'b0;
      err_set   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (mem_req_w) begin
               accept   = 1'b1;
               beat_nxt = 1'b0;
`ifdef YSYX_22050598_LINE_WRITE_EN
               state_nxt = ST_WR_REQ;
`else
               state_nxt = ST_DONE;
               err_set   = 1'b1;
`endif
            end else if (mem_req_r) begin
               accept    = 1'b1;
               beat_nxt  = 1'b0;
               state_nxt = ST_RD_REQ;
            end
         end
         ST_RD_REQ: begin
            if (bus_ready) begin
               state_nxt = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (bus_rvalid) begin
               if (!beat_r) begin
                  rlo_en    = 1'b1;
                  beat_nxt  = 1'b1;
                  state_nxt = ST_RD_REQ;
               end else begin
                  rhi_en    = 1'b1;
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_WR_REQ: begin
`ifdef YSYX_22050598_LINE_WRITE_EN
            if (bus_ready) begin
               if (!beat_r) begin
                  beat_nxt = 1'b1;
               end else begin
                  state_nxt = ST_DONE;
               end
            end
`else
            state_nxt = ST_IDLE;
`endif
         end
         ST_DONE: begin
            state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   ysyx_22050598_sirv_gnrl_dfflr #(.DW(3)) u_state (
      .clk   (clk),
      .rst_n (rst),
      .lden  (1'b1),
      .dnxt  (state_nxt),
      .qout  (state_r)
   );

   ysyx_22050598_sirv_gnrl_dfflr #(.DW(1)) u_beat (
      .clk   (clk),
      .rst_n (rst),
      .lden  (1'b1),
      .dnxt  (beat_nxt),
      .qout  (beat_r)
   );

   ysyx_22050598_sirv_gnrl_dfflr #(.DW(TAG_W)) u_line_addr (
      .clk   (clk),
      .rst_n (rst),
      .lden  (accept),
      .dnxt  (mem_req_addr[ADDR_W-1:4]),
      .qout  (line_addr_r)
   );

   ysyx_22050598_sirv_gnrl_dfflr #(.DW(BEAT_W)) u_rline_lo (
      .clk   (clk),
      .rst_n (rst),
      .lden  (rlo_en),
      .dnxt  (bus_rdata),
      .qout  (mem_r_data[BEAT_W-1:0])
   );

   ysyx_22050598_sirv_gnrl_dfflr #(.DW(BEAT_W)) u_rline_hi (
      .clk   (clk),
      .rst_n (rst),
      .lden  (rhi_en),
      .dnxt  (bus_rdata),
      .qout  (mem_r_data[LINE_W-1:BEAT_W])
   );

   ysyx_22050598_sirv_gnrl_dfflr #(.DW(1)) u_err (
      .clk   (clk),
      .rst_n (rst),
      .lden  (err_set),
      .dnxt  (1'b1),
      .qout  (bridge_err)
   );

`ifdef YSYX_22050598_LINE_WRITE_EN
   logic [LINE_W-1:0] wline_r;
   logic              unused_addr_lsb;

   ysyx_22050598_sirv_gnrl_dfflr #(.DW(LINE_W)) u_wline (
      .clk   (clk),
      .rst_n (rst),
      .lden  (accept),
      .dnxt  (mem_w_data),
      .qout  (wline_r)
   );

   assign unused_addr_lsb = ^mem_req_addr[3:0];
`else
   logic unused_inputs;

   assign unused_inputs = ^{mem_w_data, mem_req_addr[3:0]};
`endif

   // Bus outputs decode purely from registered state, so they are zero outside beat states.
   always_comb begin
      bus_req = '0;
      if (state_r == ST_RD_REQ) begin
         bus_req.valid = 1'b1;
         bus_req.addr  = beat_addr(line_addr_r, beat_r);
      end
`ifdef YSYX_22050598_LINE_WRITE_EN
      else if (state_r == ST_WR_REQ) begin
         bus_req.valid = 1'b1;
         bus_req.we    = 1'b1;
         bus_req.addr  = beat_addr(line_addr_r, beat_r);
         bus_req.wdata = beat_r ? wline_r[LINE_W-1:BEAT_W] : wline_r[BEAT_W-1:0];
         bus_req.wstrb = '1;
      end
`endif
   end

   assign bus_valid     = bus_req.valid;
   assign bus_we        = bus_req.we;
   assign bus_addr      = bus_req.addr;
   assign bus_wdata     = bus_req.wdata;
   assign bus_wstrb     = bus_req.wstrb;
   assign mem_req_ready = (state_r == ST_DONE);

endmodule
